// File: rtl/fm_radio_pkg.sv
// Shared FM-radio front-end definitions: channel filter taps,
// quantisation scale, FIR controller states and the Q-format multiply.
package fm_radio_pkg;

    localparam int QUANT_WIDTH = 10;
    localparam int CHANNEL_TAPS = 20;

    // Low-pass channel taps in Q10, index 0 applies to the newest sample.
    localparam logic signed [31:0] CHANNEL_COEFFS [CHANNEL_TAPS] = '{
        -32'sd1,  -32'sd6,  -32'sd10, -32'sd4,
        32'sd15,  32'sd42,  32'sd70,  32'sd95,
        32'sd113, 32'sd122, 32'sd122, 32'sd113,
        32'sd95,  32'sd70,  32'sd42,  32'sd15,
        -32'sd4,  -32'sd10, -32'sd6,  -32'sd1
    };

    typedef enum logic [1:0] {
        S_LOAD,
        S_MAC,
        S_OUT
    } firstate_t;

    // Full-width product, arithmetic shift (rounds toward -inf).
    // Caller keeps the low bits it needs.
    function automatic logic signed [63:0] dequantize(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 shift
    );
        logic signed [63:0] p;
        p = a * b;
        return p >>> shift;
    endfunction

endpackage

// File: rtl/fir_mac_lane.sv
// One rail of the channel FIR: sample shift register plus a single MAC.
// Ports: clock/reset, shift/clear/mac strobes and tap index from the
// controller, sample in, sum = accumulator plus the current tap term.
module fir_mac_lane
    import fm_radio_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int QUANTIZE_WIDTH = QUANT_WIDTH,
    parameter int NUM_TAPS       = 20,
    parameter int TAP_WIDTH      = $clog2(NUM_TAPS),
    parameter logic signed [DATA_WIDTH-1:0] COEFFS [NUM_TAPS] = CHANNEL_COEFFS
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         shift,
    input  logic                         clear,
    input  logic                         mac,
    input  logic [TAP_WIDTH-1:0]         tap,
    input  logic signed [DATA_WIDTH-1:0] sample,
    output logic signed [DATA_WIDTH-1:0] sum
);

    logic signed [DATA_WIDTH-1:0] x [NUM_TAPS];
    logic signed [DATA_WIDTH-1:0] acc;
    logic signed [DATA_WIDTH-1:0] term;

    // Wraps modulo 2^DATA_WIDTH by truncation.
    assign term = DATA_WIDTH'(dequantize(64'(COEFFS[tap]),
                                         64'(x[tap]),
                                         QUANTIZE_WIDTH));
    assign sum  = acc + term;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_TAPS; k++) x[k] <= '0;
            acc <= '0;
        end else begin
            if (shift) begin
                for (int k = NUM_TAPS - 1; k > 0; k--) x[k] <= x[k-1];
                x[0] <= sample;
            end
            if (clear)    acc <= '0;
            else if (mac) acc <= sum;
        end
    end

endmodule

// File: rtl/iq_channel_fir.sv
// Complex channel low-pass FIR with decimation: collects DECIMATION I/Q
// pairs, runs one MAC per tap on each rail, then holds the result.
// Ports: clock, reset (async, active low); in_available/in_rd_en with
// i_data_in/q_data_in upstream; out_available/out_rd_en with
// i_data_out/q_data_out downstream.
module iq_channel_fir
    import fm_radio_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int QUANTIZE_WIDTH = QUANT_WIDTH,
    parameter int NUM_TAPS       = 20,
    parameter int DECIMATION     = 8,
    parameter logic signed [DATA_WIDTH-1:0] COEFFS [NUM_TAPS] = CHANNEL_COEFFS
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_available,
    input  logic signed [DATA_WIDTH-1:0] i_data_in,
    input  logic signed [DATA_WIDTH-1:0] q_data_in,
    output logic                         in_rd_en,
    input  logic                         out_rd_en,
    output logic signed [DATA_WIDTH-1:0] i_data_out,
    output logic signed [DATA_WIDTH-1:0] q_data_out,
    output logic                         out_available
);

    localparam int TAP_WIDTH = $clog2(NUM_TAPS);
    localparam int CNT_WIDTH = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
    localparam logic [TAP_WIDTH-1:0] LAST_TAP = TAP_WIDTH'(NUM_TAPS - 1);
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DECIMATION - 1);

    firstate_t               state;
    logic [CNT_WIDTH-1:0]    count;
    logic [TAP_WIDTH-1:0]    tap;
    logic                    accept;
    logic                    group_done;
    logic                    mac;
    logic signed [DATA_WIDTH-1:0] i_sum;
    logic signed [DATA_WIDTH-1:0] q_sum;

    assign in_rd_en   = (state == S_LOAD);
    assign accept     = in_rd_en && in_available;
    assign group_done = accept && (count == LAST_CNT);
    assign mac        = (state == S_MAC);

    fir_mac_lane #(
        .DATA_WIDTH     (DATA_WIDTH),
        .QUANTIZE_WIDTH (QUANTIZE_WIDTH),
        .NUM_TAPS       (NUM_TAPS),
        .TAP_WIDTH      (TAP_WIDTH),
        .COEFFS         (COEFFS)
    ) u_lane_i (
        .clock  (clock),
        .reset  (reset),
        .shift  (accept),
        .clear  (group_done),
        .mac    (mac),
        .tap    (tap),
        .sample (i_data_in),
        .sum    (i_sum)
    );

    fir_mac_lane #(
        .DATA_WIDTH     (DATA_WIDTH),
        .QUANTIZE_WIDTH (QUANTIZE_WIDTH),
        .NUM_TAPS       (NUM_TAPS),
        .TAP_WIDTH      (TAP_WIDTH),
        .COEFFS         (COEFFS)
    ) u_lane_q (
        .clock  (clock),
        .reset  (reset),
        .shift  (accept),
        .clear  (group_done),
        .mac    (mac),
        .tap    (tap),
        .sample (q_data_in),
        .sum    (q_sum)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= S_LOAD;
            count         <= '0;
            tap           <= '0;
            i_data_out    <= '0;
            q_data_out    <= '0;
            out_available <= 1'b0;
        end else begin
            unique case (state)
                S_LOAD: begin
                    if (group_done) begin
                        count <= '0;
                        tap   <= '0;
                        state <= S_MAC;
                    end else if (accept) begin
                        count <= count + 1'b1;
                    end
                end
                S_MAC: begin
                    if (tap == LAST_TAP) begin
                        i_data_out    <= i_sum;
                        q_data_out    <= q_sum;
                        out_available <= 1'b1;
                        state         <= S_OUT;
                    end else begin
                        tap <= tap + 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_rd_en) begin
                        out_available <= 1'b0;
                        state         <= S_LOAD;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_iq_channel_fir.sv
// Scoreboard bench for iq_channel_fir: three instances (4-tap/dec 2,
// 4-tap/dec 1 truncation, default) driven one at a time.
module tb_iq_channel_fir;

    localparam logic signed [31:0] CA [4] = '{32'sd1024, 32'sd512, 32'sd256, 32'sd128};
    localparam logic signed [31:0] CB [4] = '{32'sd512, 32'sd0, 32'sd0, 32'sd0};

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic rst_n [3];
    logic in_av [3];
    logic in_rd [3];
    logic out_rd [3];
    logic out_av [3];
    logic signed [31:0] id [3];
    logic signed [31:0] qd [3];
    logic signed [31:0] io [3];
    logic signed [31:0] qo [3];

    iq_channel_fir #(
        .DATA_WIDTH(32), .QUANTIZE_WIDTH(10), .NUM_TAPS(4),
        .DECIMATION(2), .COEFFS(CA)
    ) u_a (
        .clock(clock), .reset(rst_n[0]), .in_available(in_av[0]),
        .i_data_in(id[0]), .q_data_in(qd[0]), .in_rd_en(in_rd[0]),
        .out_rd_en(out_rd[0]), .i_data_out(io[0]), .q_data_out(qo[0]),
        .out_available(out_av[0])
    );

    iq_channel_fir #(
        .DATA_WIDTH(32), .QUANTIZE_WIDTH(10), .NUM_TAPS(4),
        .DECIMATION(1), .COEFFS(CB)
    ) u_b (
        .clock(clock), .reset(rst_n[1]), .in_available(in_av[1]),
        .i_data_in(id[1]), .q_data_in(qd[1]), .in_rd_en(in_rd[1]),
        .out_rd_en(out_rd[1]), .i_data_out(io[1]), .q_data_out(qo[1]),
        .out_available(out_av[1])
    );

    iq_channel_fir u_c (
        .clock(clock), .reset(rst_n[2]), .in_available(in_av[2]),
        .i_data_in(id[2]), .q_data_in(qd[2]), .in_rd_en(in_rd[2]),
        .out_rd_en(out_rd[2]), .i_data_out(io[2]), .q_data_out(qo[2]),
        .out_available(out_av[2])
    );

    typedef struct {
        int                 lane;
        logic signed [31:0] i;
        logic signed [31:0] q;
    } exp_t;

    exp_t sb [$];
    exp_t e;
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int acc_cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(string nm, logic signed [31:0] act, logic signed [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Monitor: one pop per retired output.
    always @(negedge clock) begin
        for (int n = 0; n < 3; n++) begin
            if (rst_n[n] && out_av[n] && out_rd[n]) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output lane %0d: got (%0d,%0d), required none",
                             n, io[n], qo[n]);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("lane%0d_id", n), n, e.lane);
                    check($sformatf("lane%0d_i", n), io[n], e.i);
                    check($sformatf("lane%0d_q", n), qo[n], e.q);
                end
            end
        end
    end

    task automatic expect_out(int n, int i, int q);
        exp_t x;
        x.lane = n;
        x.i = i;
        x.q = q;
        sb.push_back(x);
    endtask

    task automatic send(int n, int i, int q);
        int t;
        t = 0;
        id[n] = i;
        qd[n] = q;
        in_av[n] = 1'b1;
        @(negedge clock);
        while (!in_rd[n] && t < 200) begin
            t++;
            @(negedge clock);
        end
        if (!in_rd[n]) check("send_timeout", 1, 0);
        acc_cyc = cyc;
        @(posedge clock);
        #1;
        in_av[n] = 1'b0;
    endtask

    task automatic idle(int c);
        repeat (c) @(posedge clock);
        #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(posedge clock);
            t++;
        end
        #1;
        check("drain_pending", sb.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        int bad;
        for (int n = 0; n < 3; n++) begin
            rst_n[n] = 1'b0;
            in_av[n] = 1'b0;
            out_rd[n] = 1'b1;
            id[n] = 0;
            qd[n] = 0;
        end
        #12;
        for (int n = 0; n < 3; n++) begin
            check($sformatf("rst_out_av%0d", n), out_av[n], 0);
            check($sformatf("rst_i%0d", n), io[n], 0);
            check($sformatf("rst_q%0d", n), qo[n], 0);
            check($sformatf("rst_in_rd%0d", n), in_rd[n], 1);
        end
        @(negedge clock);
        for (int n = 0; n < 3; n++) rst_n[n] = 1'b1;
        @(posedge clock);
        #1;

        // Impulse
        expect_out(0, 1024, -1024);
        expect_out(0, 256, -256);
        expect_out(0, 0, 0);
        send(0, 2048, -2048);
        for (int k = 0; k < 5; k++) send(0, 0, 0);
        drain();

        // DC gain with latency measurement
        expect_out(0, 1536, 0);
        expect_out(0, 1920, 0);
        expect_out(0, 1920, 0);
        send(0, 1024, 0);
        send(0, 1024, 0);
        t = 0;
        while (!out_av[0] && t < 100) begin
            @(negedge clock);
            t++;
        end
        check("latency", cyc - acc_cyc, 5);
        for (int k = 0; k < 4; k++) send(0, 1024, 0);
        drain();

        // Truncation toward -inf
        expect_out(1, -1, 0);
        expect_out(1, 0, 0);
        expect_out(1, -513, 0);
        send(1, -1, 0);
        send(1, 1, 0);
        send(1, -1025, 0);
        drain();

        // Backpressure
        out_rd[0] = 1'b0;
        expect_out(0, 384, 768);
        send(0, 0, 512);
        send(0, 0, 512);
        t = 0;
        while (!out_av[0] && t < 100) begin
            @(negedge clock);
            t++;
        end
        check("bp_out_av", out_av[0], 1);
        id[0] = 2048;
        qd[0] = 0;
        in_av[0] = 1'b1;
        bad = 0;
        repeat (50) begin
            @(negedge clock);
            if (in_rd[0] || !out_av[0] || io[0] !== 384 || qo[0] !== 768) bad++;
        end
        check("bp_stall_violations", bad, 0);
        @(posedge clock);
        #1;
        out_rd[0] = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("bp_resume_in_rd", in_rd[0], 1);
        check("bp_resume_out_av", out_av[0], 0);
        @(posedge clock);
        #1;
        in_av[0] = 1'b0;
        expect_out(0, 1024, 192);
        send(0, 0, 0);
        drain();

        // Upstream starvation gaps
        expect_out(0, 768, 1024);
        expect_out(0, 1152, -256);
        send(0, 1024, 0);
        idle(2);
        send(0, 0, 1024);
        idle(2);
        send(0, 2048, -1024);
        idle(2);
        send(0, 0, 0);
        drain();

        // Reset during MAC on the default instance
        expect_out(2, 201, -201);
        for (int k = 0; k < 8; k++) send(2, 1024, -1024);
        drain();
        for (int k = 0; k < 8; k++) send(2, 2048, 0);
        repeat (7) @(posedge clock);
        #1;
        rst_n[2] = 1'b0;
        #1;
        check("mid_rst_i", io[2], 0);
        check("mid_rst_q", qo[2], 0);
        check("mid_rst_out_av", out_av[2], 0);
        check("mid_rst_in_rd", in_rd[2], 1);
        @(negedge clock);
        rst_n[2] = 1'b1;
        @(posedge clock);
        #1;
        expect_out(2, 201, -201);
        for (int k = 0; k < 8; k++) send(2, 1024, -1024);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
